// File: rtl/npu_network_defines.sv
// ============================================================================
// Module   : npu_network_defines (package)
// Purpose  : Shared router network dimensions and flit types.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef PORT_NUM
`define PORT_NUM 5
`endif
`ifndef VC_PER_PORT
`define VC_PER_PORT 2
`endif

package npu_network_defines;

  localparam int PORT_NUM    = `PORT_NUM;
  localparam int VC_PER_PORT = `VC_PER_PORT;

  // Index width that stays at least one bit for degenerate sizes.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int PORT_NUM_W = width_of(PORT_NUM);
  localparam int VC_ID_W    = width_of(VC_PER_PORT);

  typedef logic [PORT_NUM_W-1:0] port_t;

  typedef enum logic [1:0] {
    FLIT_HEADER = 2'd0,
    FLIT_BODY   = 2'd1,
    FLIT_TAIL   = 2'd2,
    FLIT_HT     = 2'd3
  } flit_type_t;

endpackage

`default_nettype wire

// File: rtl/sa_rr_arbiter.sv
// ============================================================================
// Module   : sa_rr_arbiter
// Purpose  : N-way round-robin arbiter; pointer moves past the winner only
//            when the caller confirms the grant via update_en.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sa_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         update_en,
  output logic [N-1:0] grant
);

  localparam int PTR_W = (N > 1) ? $clog2(N) : 1;

  logic [PTR_W-1:0] r_ptr;
  logic [PTR_W-1:0] w_gnt_idx;
  logic             w_found;
  int               w_k;

  always_comb begin
    grant     = '0;
    w_gnt_idx = '0;
    w_found   = 1'b0;
    w_k       = 0;
    for (int i = 0; i < N; i++) begin
      w_k = (int'(r_ptr) + i) % N;
      if (!w_found && req[PTR_W'(w_k)]) begin
        w_found             = 1'b1;
        grant[PTR_W'(w_k)]  = 1'b1;
        w_gnt_idx           = PTR_W'(w_k);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
    end else if (update_en && w_found) begin
      r_ptr <= (w_gnt_idx == PTR_W'(N - 1)) ? '0 : w_gnt_idx + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/wormhole_switch_allocator.sv
// ============================================================================
// Module   : wormhole_switch_allocator
// Purpose  : Separable input-first round-robin switch allocator with
//            per-(output,VC) wormhole locks and on/off back-pressure.
//            Optional SA_PERF_COUNTERS_EN adds per-output stall/flit counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wormhole_switch_allocator #(
  parameter int  PORT_NUM    = `PORT_NUM,
  parameter int  VC_PER_PORT = `VC_PER_PORT,
  localparam int PORT_NUM_W  = npu_network_defines::width_of(PORT_NUM),
  localparam int VC_ID_W     = npu_network_defines::width_of(VC_PER_PORT)
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [PORT_NUM-1:0][VC_PER_PORT-1:0][PORT_NUM-1:0] ip_dest_port,
  input  logic [PORT_NUM-1:0][VC_PER_PORT-1:0]           ip_is_tail,
  input  logic [PORT_NUM-1:0][VC_PER_PORT-1:0]           ip_is_head,
  input  logic [PORT_NUM-1:0][VC_PER_PORT-1:0]           on_off_in,
  output logic [PORT_NUM-1:0][VC_PER_PORT-1:0]           sa_grant,
  output logic [PORT_NUM-1:0]                            xb_valid,
  output logic [PORT_NUM-1:0][PORT_NUM_W-1:0]            xb_sel_port,
  output logic [PORT_NUM-1:0][VC_ID_W-1:0]               xb_sel_vc
`ifdef SA_PERF_COUNTERS_EN
  ,
  output logic [PORT_NUM-1:0][31:0]                      sa_stall_cnt,
  output logic [PORT_NUM-1:0][31:0]                      sa_flit_cnt
`endif
);

  logic [PORT_NUM-1:0][VC_PER_PORT-1:0]                 r_lock_valid;
  logic [PORT_NUM-1:0][VC_PER_PORT-1:0][PORT_NUM_W-1:0] r_lock_owner;

  logic [PORT_NUM-1:0][VC_PER_PORT-1:0] w_elig;
  logic [PORT_NUM-1:0][VC_PER_PORT-1:0] w_in_gnt;
  logic [PORT_NUM-1:0][PORT_NUM-1:0]    w_tgt;      // [input][output]
  logic [PORT_NUM-1:0][PORT_NUM-1:0]    w_out_req;  // [output][input]
  logic [PORT_NUM-1:0][PORT_NUM-1:0]    w_out_gnt;  // [output][input]
  logic [PORT_NUM-1:0]                  w_port_won;
  logic [PORT_NUM-1:0]                  w_out_any;
  logic [PORT_NUM-1:0]                  w_win_head;
  logic [PORT_NUM-1:0]                  w_win_tail;
  logic [PORT_NUM-1:0][PORT_NUM_W-1:0]  w_win_port;
  logic [PORT_NUM-1:0][VC_ID_W-1:0]     w_win_vc;

  // A head may claim a free (o,v); otherwise only the lock owner may send.
  always_comb begin
    w_elig = '0;
    for (int p = 0; p < PORT_NUM; p++) begin
      for (int v = 0; v < VC_PER_PORT; v++) begin
        for (int o = 0; o < PORT_NUM; o++) begin
          if (ip_dest_port[p][v][o] && !on_off_in[o][v]) begin
            if (!r_lock_valid[o][v] && ip_is_head[p][v])
              w_elig[p][v] = 1'b1;
            if (r_lock_valid[o][v] && (r_lock_owner[o][v] == PORT_NUM_W'(p)))
              w_elig[p][v] = 1'b1;
          end
        end
      end
    end
  end

  generate
    for (genvar gp = 0; gp < PORT_NUM; gp++) begin : g_in_arb
      sa_rr_arbiter #(.N(VC_PER_PORT)) u_in_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (w_elig[gp]),
        .update_en (w_port_won[gp]),
        .grant     (w_in_gnt[gp])
      );
    end
  endgenerate

  always_comb begin
    w_tgt     = '0;
    w_out_req = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_PER_PORT; v++)
        if (w_in_gnt[p][v]) w_tgt[p] = w_tgt[p] | ip_dest_port[p][v];
    for (int o = 0; o < PORT_NUM; o++)
      for (int p = 0; p < PORT_NUM; p++)
        w_out_req[o][p] = w_tgt[p][o];
  end

  generate
    for (genvar go = 0; go < PORT_NUM; go++) begin : g_out_arb
      sa_rr_arbiter #(.N(PORT_NUM)) u_out_arb (
        .clk       (clk),
        .reset     (reset),
        .req       (w_out_req[go]),
        .update_en (w_out_any[go]),
        .grant     (w_out_gnt[go])
      );
    end
  endgenerate

  always_comb begin
    w_port_won = '0;
    w_out_any  = '0;
    w_win_head = '0;
    w_win_tail = '0;
    w_win_port = '0;
    w_win_vc   = '0;
    for (int o = 0; o < PORT_NUM; o++) begin
      w_out_any[o] = |w_out_gnt[o];
      for (int p = 0; p < PORT_NUM; p++) begin
        if (w_out_gnt[o][p]) begin
          w_port_won[p] = 1'b1;
          w_win_port[o] = PORT_NUM_W'(p);
          for (int v = 0; v < VC_PER_PORT; v++) begin
            if (w_in_gnt[p][v]) begin
              w_win_vc[o]   = VC_ID_W'(v);
              w_win_head[o] = ip_is_head[p][v];
              w_win_tail[o] = ip_is_tail[p][v];
            end
          end
        end
      end
    end
  end

  always_comb begin
    sa_grant    = '0;
    xb_valid    = '0;
    xb_sel_port = '0;
    xb_sel_vc   = '0;
    if (!reset) begin
      for (int p = 0; p < PORT_NUM; p++)
        sa_grant[p] = w_port_won[p] ? w_in_gnt[p] : '0;
      xb_valid    = w_out_any;
      xb_sel_port = w_win_port;
      xb_sel_vc   = w_win_vc;
    end
  end

  // Tail (including HT) releases; a pure head claims the (o,v) for its port.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lock_valid <= '0;
      r_lock_owner <= '0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        for (int v = 0; v < VC_PER_PORT; v++) begin
          if (w_out_any[o] && (w_win_vc[o] == VC_ID_W'(v))) begin
            if (w_win_tail[o]) begin
              r_lock_valid[o][v] <= 1'b0;
            end else if (w_win_head[o]) begin
              r_lock_valid[o][v] <= 1'b1;
              r_lock_owner[o][v] <= w_win_port[o];
            end
          end
        end
      end
    end
  end

`ifdef SA_PERF_COUNTERS_EN
  logic [PORT_NUM-1:0]        w_req_any;
  logic [PORT_NUM-1:0]        w_req_open;
  logic [PORT_NUM-1:0][31:0]  r_stall_cnt;
  logic [PORT_NUM-1:0][31:0]  r_flit_cnt;

  always_comb begin
    w_req_any  = '0;
    w_req_open = '0;
    for (int p = 0; p < PORT_NUM; p++)
      for (int v = 0; v < VC_PER_PORT; v++)
        for (int o = 0; o < PORT_NUM; o++)
          if (ip_dest_port[p][v][o]) begin
            w_req_any[o] = 1'b1;
            if (!on_off_in[o][v]) w_req_open[o] = 1'b1;
          end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= '0;
      r_flit_cnt  <= '0;
    end else begin
      for (int o = 0; o < PORT_NUM; o++) begin
        if (w_req_any[o] && !w_req_open[o] && (r_stall_cnt[o] != '1))
          r_stall_cnt[o] <= r_stall_cnt[o] + 32'd1;
        if (w_out_any[o] && (r_flit_cnt[o] != '1))
          r_flit_cnt[o] <= r_flit_cnt[o] + 32'd1;
      end
    end
  end

  assign sa_stall_cnt = r_stall_cnt;
  assign sa_flit_cnt  = r_flit_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_wormhole_switch_allocator.sv
// ============================================================================
// Module   : tb_wormhole_switch_allocator
// Purpose  : Scenario-driven scoreboard bench for wormhole_switch_allocator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wormhole_switch_allocator;

  localparam int P  = 5;
  localparam int V  = 2;
  localparam int PW = 3;
  localparam int VW = 1;
  localparam int OW = P * V + P + P * PW + P * VW;

  logic clk;
  logic reset;
  logic [P-1:0][V-1:0][P-1:0] ip_dest_port;
  logic [P-1:0][V-1:0]        ip_is_tail;
  logic [P-1:0][V-1:0]        ip_is_head;
  logic [P-1:0][V-1:0]        on_off_in;
  logic [P-1:0][V-1:0]        sa_grant;
  logic [P-1:0]               xb_valid;
  logic [P-1:0][PW-1:0]       xb_sel_port;
  logic [P-1:0][VW-1:0]       xb_sel_vc;
`ifdef SA_PERF_COUNTERS_EN
  logic [P-1:0][31:0]         sa_stall_cnt;
  logic [P-1:0][31:0]         sa_flit_cnt;
`endif

  wormhole_switch_allocator #(.PORT_NUM(P), .VC_PER_PORT(V)) dut (
    .clk          (clk),
    .reset        (reset),
    .ip_dest_port (ip_dest_port),
    .ip_is_tail   (ip_is_tail),
    .ip_is_head   (ip_is_head),
    .on_off_in    (on_off_in),
    .sa_grant     (sa_grant),
    .xb_valid     (xb_valid),
    .xb_sel_port  (xb_sel_port),
    .xb_sel_vc    (xb_sel_vc)
`ifdef SA_PERF_COUNTERS_EN
    ,
    .sa_stall_cnt (sa_stall_cnt),
    .sa_flit_cnt  (sa_flit_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [OW-1:0] sb[$];
  logic [P-1:0][V-1:0]  e_grant;
  logic [P-1:0]         e_valid;
  logic [P-1:0][PW-1:0] e_sport;
  logic [P-1:0][VW-1:0] e_svc;
  logic [OW-1:0]        exp_v;
  logic [OW-1:0]        obs_v;
  bit                   have_exp;

  task automatic clr();
    ip_dest_port = '0;
    ip_is_head   = '0;
    ip_is_tail   = '0;
    on_off_in    = '0;
  endtask

  task automatic req(input int p, input int v, input int o, input bit h, input bit t);
    ip_dest_port[p][v]    = '0;
    ip_dest_port[p][v][o] = 1'b1;
    ip_is_head[p][v]      = h;
    ip_is_tail[p][v]      = t;
  endtask

  task automatic e_clear();
    e_grant = '0;
    e_valid = '0;
    e_sport = '0;
    e_svc   = '0;
  endtask

  task automatic e_win(input int p, input int v, input int o);
    e_grant[p][v] = 1'b1;
    e_valid[o]    = 1'b1;
    e_sport[o]    = PW'(p);
    e_svc[o]      = VW'(v);
  endtask

  task automatic e_push();
    sb.push_back({e_grant, e_valid, e_sport, e_svc});
  endtask

  // Move to the sampling edge and fetch the expectation for this cycle.
  task automatic wait_out();
    @(negedge clk);
    obs_v = {sa_grant, xb_valid, xb_sel_port, xb_sel_vc};
    if (sb.size() == 0) begin
      have_exp = 1'b0;
      exp_v    = '0;
    end else begin
      have_exp = 1'b1;
      exp_v    = sb.pop_front();
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int c = 0; c < 3; c++) begin
      clr();
      if (c < 2) req(0, 0, 0, 1'b1, 1'b1);
      e_clear(); e_push();
      wait_out();
      n_checks++;
      if (!have_exp || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset cycle %0d: got %h required %h", c, obs_v, exp_v);
      end
      next_cycle();
      if (c == 1) reset = 1'b0;
    end
  endtask

  task automatic test_single_ht();
    for (int c = 0; c < 3; c++) begin
      clr(); e_clear();
      case (c)
        0: begin req(0, 1, 2, 1'b1, 1'b1); e_win(0, 1, 2); end
        1: begin req(3, 1, 2, 1'b1, 1'b1); e_win(3, 1, 2); end
        default: begin
          req(2, 0, 0, 1'b1, 1'b1); e_win(2, 0, 0);
          req(1, 1, 2, 1'b1, 1'b1); e_win(1, 1, 2);
          req(4, 0, 3, 1'b1, 1'b1); e_win(4, 0, 3);
        end
      endcase
      e_push();
      wait_out();
      n_checks++;
      if (!have_exp || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL single_ht cycle %0d: got %h required %h", c, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_alternate();
    for (int c = 0; c < 4; c++) begin
      clr(); e_clear();
      req(0, 0, 3, 1'b1, 1'b1);
      req(0, 1, 3, 1'b1, 1'b1);
      e_win(0, c % 2, 3);
      e_push();
      wait_out();
      n_checks++;
      if (!have_exp || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL alternate cycle %0d: got %h required %h", c, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_wormhole();
    for (int c = 0; c < 7; c++) begin
      clr(); e_clear();
      case (c)
        0: begin req(1, 0, 4, 1'b1, 1'b0); req(3, 0, 4, 1'b1, 1'b0); e_win(1, 0, 4); end
        1: begin req(1, 0, 4, 1'b0, 1'b0); req(3, 0, 4, 1'b1, 1'b0); e_win(1, 0, 4); end
        2: begin req(1, 0, 4, 1'b0, 1'b1); req(3, 0, 4, 1'b1, 1'b0); e_win(1, 0, 4); end
        3: begin req(3, 0, 4, 1'b1, 1'b0); e_win(3, 0, 4); end
        4: begin req(3, 0, 4, 1'b0, 1'b0); e_win(3, 0, 4); end
        5: begin req(3, 0, 4, 1'b0, 1'b1); e_win(3, 0, 4); end
        default: req(1, 0, 4, 1'b0, 1'b0);
      endcase
      e_push();
      wait_out();
      n_checks++;
      if (!have_exp || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL wormhole cycle %0d: got %h required %h", c, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_on_off();
    for (int c = 0; c < 8; c++) begin
      clr(); e_clear();
      if (c == 0) begin
        req(2, 0, 1, 1'b1, 1'b0); e_win(2, 0, 1);
      end else if (c <= 4) begin
        req(2, 0, 1, 1'b0, 1'b0);
        req(0, 0, 1, 1'b1, 1'b0);
        on_off_in[1][0] = 1'b1;
        if (c == 2) begin req(3, 1, 1, 1'b1, 1'b1); e_win(3, 1, 1); end
      end else if (c <= 6) begin
        req(2, 0, 1, 1'b0, (c == 6));
        req(0, 0, 1, 1'b1, 1'b0);
        e_win(2, 0, 1);
      end else begin
        req(0, 0, 1, 1'b1, 1'b1); e_win(0, 0, 1);
      end
      e_push();
      wait_out();
      n_checks++;
      if (!have_exp || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL on_off cycle %0d: got %h required %h", c, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

  task automatic test_reset_mid_packet();
    for (int c = 0; c < 4; c++) begin
      clr(); e_clear();
      if (c == 0) begin
        req(4, 1, 0, 1'b1, 1'b0); e_win(4, 1, 0);
      end else begin
        reset = (c <= 2);
        req(4, 1, 0, 1'b0, 1'b0);
        req(2, 1, 0, 1'b1, 1'b0);
        if (c == 3) e_win(2, 1, 0);
      end
      e_push();
      wait_out();
      n_checks++;
      if (!have_exp || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL reset_mid cycle %0d: got %h required %h", c, obs_v, exp_v);
      end
      next_cycle();
    end
  endtask

`ifdef SA_PERF_COUNTERS_EN
  task automatic test_perf_counters();
    clr();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 15; c++) begin
      clr(); e_clear();
      req(1, 0, 0, 1'b1, 1'b1);
      if (c < 10) on_off_in[0][0] = 1'b1;
      else        e_win(1, 0, 0);
      e_push();
      wait_out();
      n_checks++;
      if (!have_exp || obs_v !== exp_v) begin
        n_fail++;
        $display("FAIL perf_traffic cycle %0d: got %h required %h", c, obs_v, exp_v);
      end
      next_cycle();
    end
    clr();
    @(negedge clk);
    n_checks++;
    if (sa_stall_cnt[0] !== 32'd10) begin
      n_fail++;
      $display("FAIL stall_cnt: got %0d required 10", sa_stall_cnt[0]);
    end
    n_checks++;
    if (sa_flit_cnt[0] !== 32'd5) begin
      n_fail++;
      $display("FAIL flit_cnt: got %0d required 5", sa_flit_cnt[0]);
    end
    next_cycle();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    clr();
    #1;
    test_reset();
    test_single_ht();
    test_alternate();
    test_wormhole();
    test_on_off();
    test_reset_mid_packet();
`ifdef SA_PERF_COUNTERS_EN
    test_perf_counters();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
